// File: rtl/usb_fault_injector_if.sv
// Byte-stream channel with valid/ready handshake and packet markers.
// master drives the byte, slave returns ready.
interface usb_fault_injector_if #(
    parameter int unsigned DATA_W = 8
) ();
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic              sop;
    logic              eop;

    modport master (output valid, output data, output sop, output eop, input ready);
    modport slave  (input valid, input data, input sop, input eop, output ready);
endinterface

// File: rtl/usb_fault_injector.sv
// Packet-level fault injector for the USB host/device byte stream: garbles,
// drops or NAK-substitutes the next N packets behind one output register stage.
module usb_fault_injector #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned CNT_W   = 4,
    parameter int unsigned IDX_W   = 4,
    parameter logic [7:0]  NAK_PID = 8'h5A
) (
    input  logic                    clk,
    input  logic                    rst_L,
    usb_fault_injector_if.slave     up,
    usb_fault_injector_if.master    dn,
    input  logic                    arm,
    input  logic [1:0]              mode,
    input  logic [CNT_W-1:0]        count,
    input  logic [IDX_W-1:0]        garble_idx,
    input  logic [DATA_W-1:0]       garble_mask,
    output logic [CNT_W-1:0]        faults_left,
    output logic                    inj_pulse
);

    localparam logic [IDX_W-1:0]  IDX_MAX = '1;
    localparam logic [DATA_W-1:0] NAK_VAL = DATA_W'(NAK_PID);

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_GARBLE = 2'd1,
        MODE_DROP   = 2'd2,
        MODE_NAK    = 2'd3
    } mode_e;

    // configuration (live) and per-packet latched copy
    mode_e              cfg_mode_q,    cfg_mode_d;
    logic [IDX_W-1:0]   cfg_idx_q,     cfg_idx_d;
    logic [DATA_W-1:0]  cfg_mask_q,    cfg_mask_d;
    logic [CNT_W-1:0]   faults_left_q, faults_left_d;
    logic               in_pkt_q,      in_pkt_d;
    logic               pkt_fault_q,   pkt_fault_d;
    mode_e              pkt_mode_q,    pkt_mode_d;
    logic [IDX_W-1:0]   pkt_idx_q,     pkt_idx_d;
    logic [DATA_W-1:0]  pkt_mask_q,    pkt_mask_d;
    logic [IDX_W-1:0]   byte_idx_q,    byte_idx_d;
    logic               nak_done_q,    nak_done_d;

    // output stage
    logic               out_valid_q,   out_valid_d;
    logic [DATA_W-1:0]  out_data_q,    out_data_d;
    logic               out_sop_q,     out_sop_d;
    logic               out_eop_q,     out_eop_d;
    logic               inj_pulse_q,   inj_pulse_d;

    logic               in_ready_c;
    logic               acc, start, term_dec, eop_dec, new_fault;
    logic               cur_in_pkt, cur_fault, cur_nak_done, load;
    mode_e              cur_mode;
    logic [IDX_W-1:0]   cur_idx, cur_gidx;
    logic [DATA_W-1:0]  cur_mask, ld_data;
    logic               ld_sop, ld_eop;
    logic [CNT_W-1:0]   fl_base, fl_next;

    assign in_ready_c  = !out_valid_q || dn.ready;
    assign up.ready    = in_ready_c;
    assign dn.valid    = out_valid_q;
    assign dn.data     = out_data_q;
    assign dn.sop      = out_sop_q;
    assign dn.eop      = out_eop_q;
    assign faults_left = faults_left_q;
    assign inj_pulse   = inj_pulse_q;

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            cfg_mode_q    <= MODE_OFF;
            cfg_idx_q     <= '0;
            cfg_mask_q    <= '0;
            faults_left_q <= '0;
            in_pkt_q      <= 1'b0;
            pkt_fault_q   <= 1'b0;
            pkt_mode_q    <= MODE_OFF;
            pkt_idx_q     <= '0;
            pkt_mask_q    <= '0;
            byte_idx_q    <= '0;
            nak_done_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_sop_q     <= 1'b0;
            out_eop_q     <= 1'b0;
            inj_pulse_q   <= 1'b0;
        end else begin
            cfg_mode_q    <= cfg_mode_d;
            cfg_idx_q     <= cfg_idx_d;
            cfg_mask_q    <= cfg_mask_d;
            faults_left_q <= faults_left_d;
            in_pkt_q      <= in_pkt_d;
            pkt_fault_q   <= pkt_fault_d;
            pkt_mode_q    <= pkt_mode_d;
            pkt_idx_q     <= pkt_idx_d;
            pkt_mask_q    <= pkt_mask_d;
            byte_idx_q    <= byte_idx_d;
            nak_done_q    <= nak_done_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_sop_q     <= out_sop_d;
            out_eop_q     <= out_eop_d;
            inj_pulse_q   <= inj_pulse_d;
        end
    end

    always_comb begin
        cfg_mode_d    = cfg_mode_q;
        cfg_idx_d     = cfg_idx_q;
        cfg_mask_d    = cfg_mask_q;
        faults_left_d = faults_left_q;
        in_pkt_d      = in_pkt_q;
        pkt_fault_d   = pkt_fault_q;
        pkt_mode_d    = pkt_mode_q;
        pkt_idx_d     = pkt_idx_q;
        pkt_mask_d    = pkt_mask_q;
        byte_idx_d    = byte_idx_q;
        nak_done_d    = nak_done_q;
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        out_sop_d     = out_sop_q;
        out_eop_d     = out_eop_q;
        inj_pulse_d   = 1'b0;

        acc   = up.valid && in_ready_c;
        start = acc && up.sop;

        // a sop inside a packet first closes the old packet, then decides the new one
        term_dec = start && in_pkt_q && pkt_fault_q;
        fl_base  = faults_left_q;
        if (term_dec && (faults_left_q != '0)) fl_base = faults_left_q - CNT_W'(1);
        new_fault = (fl_base != '0) && (cfg_mode_q != MODE_OFF);

        cur_in_pkt   = start || in_pkt_q;
        cur_fault    = start ? new_fault  : (in_pkt_q && pkt_fault_q);
        cur_mode     = start ? cfg_mode_q : pkt_mode_q;
        cur_gidx     = start ? cfg_idx_q  : pkt_idx_q;
        cur_mask     = start ? cfg_mask_q : pkt_mask_q;
        cur_idx      = start ? '0         : byte_idx_q;
        cur_nak_done = start ? 1'b0       : nak_done_q;

        // byte transform for the output register
        load    = 1'b0;
        ld_data = up.data;
        ld_sop  = up.sop;
        ld_eop  = up.eop;
        if (acc) begin
            load = 1'b1;
            if (cur_fault) begin
                case (cur_mode)
                    MODE_GARBLE: if (cur_idx == cur_gidx) ld_data = up.data ^ cur_mask;
                    MODE_DROP:   load = 1'b0;
                    MODE_NAK: begin
                        if (cur_nak_done) begin
                            load = 1'b0;
                        end else begin
                            ld_data = NAK_VAL;
                            ld_sop  = 1'b1;
                            ld_eop  = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end

        if (out_valid_q && dn.ready) out_valid_d = 1'b0;
        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = ld_data;
            out_sop_d   = ld_sop;
            out_eop_d   = ld_eop;
        end

        if (start) begin
            pkt_fault_d = new_fault;
            pkt_mode_d  = cfg_mode_q;
            pkt_idx_d   = cfg_idx_q;
            pkt_mask_d  = cfg_mask_q;
            inj_pulse_d = new_fault;
        end

        if (acc && cur_in_pkt) begin
            byte_idx_d = (cur_idx == IDX_MAX) ? IDX_MAX : cur_idx + IDX_W'(1);
            nak_done_d = cur_nak_done || (cur_fault && (cur_mode == MODE_NAK));
            in_pkt_d   = !up.eop;
        end

        eop_dec = acc && up.eop && cur_in_pkt && cur_fault;
        fl_next = fl_base;
        if (eop_dec && (fl_base != '0)) fl_next = fl_base - CNT_W'(1);

        // arm overrides any same-cycle decrement
        if (arm) begin
            cfg_mode_d    = mode_e'(mode);
            cfg_idx_d     = garble_idx;
            cfg_mask_d    = garble_mask;
            faults_left_d = ((count == '0) || (mode == 2'd0)) ? '0 : count;
        end else begin
            faults_left_d = fl_next;
        end
    end

endmodule
